bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Parametrised, multi-cycle double-dabble binary-to-BCD converter with valid/ready handshakes.
//  Sits between the time counters (sec/min/hour/date) and the seven-segment display driver.
//  Converts any BIN_W-bit value into DIGITS packed BCD nibbles, one bit per clock.
//  Flags values that do not fit in DIGITS digits.
// PARAMETERS
//  BIN_W   6  width of binary input, 1..32
//  DIGITS  2  number of BCD output digits, 1..10; fewer than needed is legal (see ovf)
// PORTS
//  clk        in   1         single system clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         bin_in is valid
//  in_ready   out  1         converter can accept (high only in IDLE)
//  bin_in     in   BIN_W     unsigned binary value
//  out_valid  out  1         bcd_out/ovf are valid; held until out_ready
//  out_ready  in   1         consumer accepts result
//  bcd_out    out  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
//  ovf        out  1         value >= 10**DIGITS; bcd_out = value mod 10**DIGITS
// BEHAVIOUR
//  Clocking: single clock domain; clock port clk; reset rst is synchronous and active-high.
//  Reset: state=IDLE; in_ready=1; out_valid=0; bcd_out=0; ovf=0; counter=0; shift reg=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready: load bin reg=bin_in, BCD reg=0, ovf=0, cnt=BIN_W; go SHIFT.
//   SHIFT: per cycle, first each nibble >=5 gets +3; then shift {BCD,bin} left 1.
//    A 1 shifted out of the top nibble sets sticky ovf. cnt--. After cnt 1->0, go DONE.
//   DONE: out_valid=1; bcd_out/ovf stable. On out_ready, go IDLE with out_valid=0 on the next cycle.
//  Latency: out_valid first high exactly BIN_W cycles after the accepting edge.
//   Throughput: one conversion per BIN_W+2 cycles minimum.
//  in_valid outside IDLE is ignored, with no side effects. bin_in is captured only at acceptance.
//  bcd_out holds its last result through the following IDLE; it updates only on entry to DONE.
//  Zero input gives all-zero digits and ovf=0. Max input with enough digits gives ovf=0.
//  rst during SHIFT or DONE aborts the conversion: reset values next cycle, result discarded.
//  Only in_valid&in_ready acts in IDLE; only out_ready acts in DONE; no simultaneous-event conflicts.
// CONFIGURATION
//  BIN2BCD_BLANK_EN defined:
//   adds output blank  out  DIGITS.
//   blank[i]=1 iff digit i and all higher digits are 0, with i>0; blank[0] is always 0.
//   Registered with bcd_out and reset to 0.
//   Drives leading-zero suppression in the display.
//  BIN2BCD_BLANK_EN undefined: port absent; no extra logic.
// STRUCTURE
//  Package bin2bcd_pkg: FSM state localparams (IDLE/SHIFT/DONE, 2-bit).
//   Also a constant function clog2, used for the cnt width.
//   Also a function digits_for(bin_w), used by parents to size DIGITS.
//  Sub-module bcd_digit_adj: 4-bit in/out, +3 if >=5; instantiated DIGITS times via generate.
//  Top: FSM, counter, {BCD,bin} shift register, ovf flag, optional blank logic.
// TESTING
//  BIN_W=6,DIGITS=2: bin_in=59 -> bcd_out=8'h59, ovf=0, out_valid after exactly 6 cycles.
//  BIN_W=6,DIGITS=2: bin_in=0 then 63 back-to-back -> 8'h00 then 8'h63, both ovf=0.
//  BIN_W=8,DIGITS=2: bin_in=255 -> bcd_out=8'h55, ovf=1.
//   BIN_W=8,DIGITS=3: 255 -> 12'h255, ovf=0.
//  Backpressure: out_ready low 5 cycles in DONE -> out_valid/bcd_out held, in_ready=0.
//   Pulse in_valid with bin_in=12 meanwhile -> that input is ignored.
//  rst asserted at SHIFT cycle 3 of bin_in=45 -> next cycle IDLE, out_valid=0, bcd_out=0.
//   Then 45 converts to 8'h45.
//  BIN2BCD_BLANK_EN, BIN_W=8,DIGITS=3: 7 -> blank=3'b110; 40 -> 3'b100; 0 -> 3'b110.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
// Parents size DIGITS with digits_for(); the top sizes its bit counter with clog2().
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Decimal digits needed for the largest bin_w-bit unsigned value.
    function automatic int digits_for(input int bin_w);
        longint unsigned max_v;
        int d;
        max_v = (64'd1 << bin_w) - 64'd1;
        d = 1;
        while (max_v >= 64'd10) begin
            max_v = max_v / 64'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One double-dabble correction step for a single BCD digit.
// Adds 3 to any digit of 5 or more so the following left shift carries into the next digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble converter with valid/ready handshakes, one input bit per clock.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero blank output.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(BIN_W + 1);
    localparam int CAT_W = BCD_W + BIN_W;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] res_q, res_d;
    logic [BCD_W-1:0] adj;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             ovf_q, ovf_d;
    logic             res_ovf_q, res_ovf_d;
    logic             load_res;
    logic [CAT_W-1:0] cat;
    logic [CAT_W-1:0] shl;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign cat = {adj, bin_q};
    assign shl = {cat[CAT_W-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        load_res  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A carry out of the top digit means the value needs more digits.
                {bcd_d, bin_d} = shl;
                ovf_d = ovf_q | adj[BCD_W-1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    res_d     = shl[CAT_W-1 -: BCD_W];
                    res_ovf_d = ovf_d;
                    load_res  = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = res_q;
    assign ovf       = res_ovf_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Digit i blanks only when it and every digit above it are zero.
    always_comb begin
        logic zero;
        blank_d = blank_q;
        zero    = 1'b1;
        if (load_res) begin
            blank_d = '0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero       = zero & (res_d[4*i +: 4] == 4'd0);
                blank_d[i] = zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (6/2, 8/2, 8/3) share clock, reset and data.
// Expected results are queued at drive time and popped when each instance hands off a result.
module tb_bin2bcd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_valid;
    logic [7:0] bin_in;
    logic       out_ready;

    logic        a_ir, a_ov, a_ovf;
    logic [7:0]  a_bcd;
    logic        b_ir, b_ov, b_ovf;
    logic [7:0]  b_bcd;
    logic        c_ir, c_ov, c_ovf;
    logic [11:0] c_bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [1:0]  a_blank;
    logic [1:0]  b_blank;
    logic [2:0]  c_blank;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [12:0] qa[$];
    logic [12:0] qb[$];
    logic [12:0] qc[$];
    logic [12:0] ea, eb, ec;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(6), .DIGITS(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(a_ir),
        .bin_in(bin_in[5:0]), .out_valid(a_ov), .out_ready(out_ready),
        .bcd_out(a_bcd), .ovf(a_ovf)
`ifdef BIN2BCD_BLANK_EN
        , .blank(a_blank)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(b_ir),
        .bin_in(bin_in), .out_valid(b_ov), .out_ready(out_ready),
        .bcd_out(b_bcd), .ovf(b_ovf)
`ifdef BIN2BCD_BLANK_EN
        , .blank(b_blank)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(c_ir),
        .bin_in(bin_in), .out_valid(c_ov), .out_ready(out_ready),
        .bcd_out(c_bcd), .ovf(c_ovf)
`ifdef BIN2BCD_BLANK_EN
        , .blank(c_blank)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, bcd} for value v shown on d digits.
    function automatic logic [12:0] model(input int v, input int d);
        logic [12:0] r;
        int p, rem;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        r = '0;
        r[12] = (v >= p);
        rem = v % p;
        for (int i = 0; i < d; i++) begin
            r[i*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    function automatic logic [2:0] blank_of(input logic [11:0] b, input int d);
        logic [2:0] r;
        logic z;
        r = '0;
        z = 1'b1;
        for (int i = d - 1; i >= 1; i--) begin
            z = z & (b[i*4 +: 4] == 4'd0);
            r[i] = z;
        end
        return r;
    endfunction

    function automatic logic ov_of(input int s);
        case (s)
            0: return a_ov;
            1: return b_ov;
            default: return c_ov;
        endcase
    endfunction

    function automatic logic ir_of(input int s);
        case (s)
            0: return a_ir;
            1: return b_ir;
            default: return c_ir;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && a_ov && out_ready) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_unexpected: got result %0h required none", a_bcd);
            end else begin
                ea = qa.pop_front();
                check("a_bcd", a_bcd, ea[7:0]);
                check("a_ovf", a_ovf, ea[12]);
`ifdef BIN2BCD_BLANK_EN
                check("a_blank", {1'b0, a_blank}, blank_of(ea[11:0], 2));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_ov && out_ready) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected: got result %0h required none", b_bcd);
            end else begin
                eb = qb.pop_front();
                check("b_bcd", b_bcd, eb[7:0]);
                check("b_ovf", b_ovf, eb[12]);
`ifdef BIN2BCD_BLANK_EN
                check("b_blank", {1'b0, b_blank}, blank_of(eb[11:0], 2));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_ov && out_ready) begin
            if (qc.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL c_unexpected: got result %0h required none", c_bcd);
            end else begin
                ec = qc.pop_front();
                check("c_bcd", c_bcd, ec[11:0]);
                check("c_ovf", c_ovf, ec[12]);
`ifdef BIN2BCD_BLANK_EN
                check("c_blank", c_blank, blank_of(ec[11:0], 3));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one value and wait for out_valid; latency counted from the accepting edge.
    task automatic convert(input int sel, input int v);
        int bw;
        int n;
        bw = (sel == 0) ? 6 : 8;
        case (sel)
            0: qa.push_back(model(v, 2));
            1: qb.push_back(model(v, 2));
            default: qc.push_back(model(v, 3));
        endcase
        check("in_ready_before", ir_of(sel), 1'b1);
        bin_in = v[7:0];
        in_valid[sel] = 1'b1;
        step();
        in_valid = '0;
        n = 0;
        do begin
            step();
            n++;
        end while (!ov_of(sel) && n < 60);
        check("latency", n, bw);
    endtask

    // Conversion with out_ready high: one more edge completes the handoff.
    task automatic run(input int sel, input int v);
        convert(sel, v);
        step();
        check("idle_after", ir_of(sel), 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        bin_in    = '0;
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_in_ready", a_ir, 1'b1);
        check("rst_out_valid", a_ov, 1'b0);
        check("rst_bcd", a_bcd, 8'h00);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_c_bcd", c_bcd, 12'h000);
        check("rst_c_ready", c_ir, 1'b1);
        rst = 1'b0;
        step();

        run(0, 59);
        run(0, 0);
        run(0, 63);
        run(1, 255);
        run(1, 99);
        run(1, 100);
        run(2, 255);
        run(2, 7);
        run(2, 40);
        run(2, 0);
        run(2, 100);

        // Backpressure: result held while in_valid pulses are ignored.
        out_ready = 1'b0;
        convert(0, 42);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bin_in = 8'd12;
                in_valid[0] = 1'b1;
            end
            step();
            in_valid = '0;
            check("bp_out_valid", a_ov, 1'b1);
            check("bp_in_ready", a_ir, 1'b0);
            check("bp_bcd", a_bcd, 8'h42);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", a_ov, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_idle_valid", a_ov, 1'b0);
            check("hold_idle_bcd", a_bcd, 8'h42);
        end

        // Abort in the middle of a conversion.
        bin_in = 8'd45;
        in_valid[0] = 1'b1;
        step();
        in_valid = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", a_ir, 1'b1);
        check("abort_out_valid", a_ov, 1'b0);
        check("abort_bcd", a_bcd, 8'h00);
        check("abort_ovf", a_ovf, 1'b0);
        run(0, 45);

        for (int i = 0; i < 6; i++) begin
            run(1, int'($urandom_range(0, 255)));
            run(2, int'($urandom_range(0, 255)));
        end

        repeat (3) step();
        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        check("qc_empty", qc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
